// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide: shift-add multiply, restoring divide, fixed latency.
// Optional build macro MULTDIV_EARLY_DIV0_EN: divide by zero finishes one cycle after the start.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_count;
  logic               r_op_div;
  logic               r_neg;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;

  logic               w_start;
  logic               w_start_div;
  logic               w_done;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH-1:0]   w_quot_signed;
  logic [WIDTH-1:0]   w_res;
  logic               w_exc;

  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_done      = (r_state == S_DONE);
  assign w_a_mag     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_b_mag     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a start overrides whatever is in flight
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_RUN:  if (r_count == CW'(WIDTH-1)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = S_RUN;
`ifdef MULTDIV_EARLY_DIV0_EN
      if (w_start_div && (data_operandB == '0)) w_state_nxt = S_DONE;
`endif
    end
  end

  // One iteration of each algorithm on magnitudes
  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    w_mul_step = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[2*WIDTH-1:1]};
    w_rem_sh   = {r_rem, r_quot[WIDTH-1]};
    w_trial    = w_rem_sh + {1'b1, ~r_a} + (WIDTH+1)'(1);
    w_qbit     = ~w_trial[WIDTH];
  end

  // Output logic: sign restore and exception detection for the DONE cycle
  always_comb begin
    w_prod_signed = r_neg ? (~r_prod + (2*WIDTH)'(1)) : r_prod;
    w_quot_signed = r_neg ? (~r_quot + WIDTH'(1)) : r_quot;
    w_res         = w_prod_signed[WIDTH-1:0];
    w_exc         = ~((&w_prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_signed[2*WIDTH-1:WIDTH-1]));
    if (r_op_div) begin
      if (r_a == '0) begin
        w_res = '0;
        w_exc = 1'b1;
      end else begin
        // only MIN / -1 yields a positive quotient magnitude of 2^31
        w_res = w_quot_signed;
        w_exc = r_quot[WIDTH-1] & ~r_neg;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_op_div       <= 1'b0;
      r_neg          <= 1'b0;
      r_a            <= '0;
      r_prod         <= '0;
      r_rem          <= '0;
      r_quot         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= w_done;
      busy           <= (r_state != S_IDLE);
      if (w_done) begin
        data_result    <= w_res;
        data_exception <= w_exc;
      end
      if (w_start) begin
        r_count  <= '0;
        r_op_div <= w_start_div;
        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        if (w_start_div) begin
          r_a    <= w_b_mag;
          r_quot <= w_a_mag;
          r_rem  <= '0;
        end else begin
          r_a    <= w_a_mag;
          r_prod <= {{WIDTH{1'b0}}, w_b_mag};
        end
      end else if (r_state == S_RUN) begin
        r_count <= r_count + CW'(1);
        if (r_op_div) begin
          r_rem  <= w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], w_qbit};
        end else begin
          r_prod <= w_mul_step;
        end
      end
    end
  end

endmodule
